// File: rtl/park_gate_arbiter.sv
// Gate arbiter for a car park barrier.
// Two entry gates and two exit gates share one barrier. One transaction runs at a time,
// in the order open -> car crosses -> commit pulse -> close.
// Optional feature macro: PARK_TIMEOUT_EN. When it is defined, an OPEN state that waits
// too long is aborted and timeout_err pulses.
module park_gate_arbiter #(
   parameter int unsigned CAPACITY     = 12,
   parameter int unsigned CLOSE_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] entry_req,
   input  logic [1:0] exit_req,
   input  logic       car_pass,
   input  logic [3:0] free_spots,
   input  logic       parking_full,
   output logic [3:0] gnt,
   output logic       barrier_open,
   output logic       car_in,
   output logic       car_out,
   output logic       busy,
   output logic       timeout_err
);

   localparam int unsigned CloseW = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StOpen, StCommit, StClose} state_e;

   state_e            state_q;
   logic [1:0]        ptr_q;
   logic [CloseW-1:0] close_cnt_q;

   logic [3:0] elig;
   logic [1:0] idx;
   logic [1:0] pick_idx;
   logic       pick_vld;
   logic [3:0] pick_oh;

   // Eligible requests, then a round-robin pick starting just after the last grant.
   always_comb begin
      elig     = {exit_req & {2{free_spots != 4'(CAPACITY)}}, entry_req & {2{~parking_full}}};
      idx      = ptr_q;
      pick_idx = ptr_q;
      pick_vld = 1'b0;
      // Walk from lowest to highest priority so the nearest eligible index wins.
      for (int k = 4; k >= 1; k--) begin
         idx = ptr_q + 2'(k);
         if (elig[idx]) begin
            pick_idx = idx;
            pick_vld = 1'b1;
         end
      end
      pick_oh = 4'b0001 << pick_idx;
   end

`ifdef PARK_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TmoW-1:0] tmo_cnt_q;
`else
   assign timeout_err = 1'b0;
`endif

   // Transaction FSM; every output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         ptr_q        <= 2'd3;
         close_cnt_q  <= '0;
         gnt          <= '0;
         barrier_open <= 1'b0;
         car_in       <= 1'b0;
         car_out      <= 1'b0;
         busy         <= 1'b0;
`ifdef PARK_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         timeout_err  <= 1'b0;
`endif
      end else begin
         car_in  <= 1'b0;
         car_out <= 1'b0;
`ifdef PARK_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state_q)
            StIdle: begin
               if (pick_vld) begin
                  state_q      <= StOpen;
                  gnt          <= pick_oh;
                  ptr_q        <= pick_idx;
                  barrier_open <= 1'b1;
                  busy         <= 1'b1;
`ifdef PARK_TIMEOUT_EN
                  tmo_cnt_q    <= '0;
`endif
               end
            end
            StOpen: begin
               if (car_pass) begin
                  state_q <= StCommit;
                  car_in  <= |gnt[1:0];
                  car_out <= |gnt[3:2];
`ifdef PARK_TIMEOUT_EN
               end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                  // Abort: close without reporting a car to the park system.
                  state_q      <= StClose;
                  gnt          <= '0;
                  barrier_open <= 1'b0;
                  timeout_err  <= 1'b1;
                  close_cnt_q  <= '0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
               end
            end
            StCommit: begin
               state_q      <= StClose;
               gnt          <= '0;
               barrier_open <= 1'b0;
               close_cnt_q  <= '0;
            end
            StClose: begin
               if (close_cnt_q == CloseW'(CLOSE_CYCLES - 1)) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else begin
                  close_cnt_q <= close_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_park_gate_arbiter.sv
// Randomized bench for park_gate_arbiter. A transaction-level model predicts the outputs of
// every cycle into a queue, and a monitor compares them at the falling edge.
module tb_park_gate_arbiter;

   localparam int unsigned CAPACITY     = 12;
   localparam int unsigned CLOSE_CYCLES = 4;
   localparam int unsigned TIMEOUT      = 16;
`ifdef PARK_TIMEOUT_EN
   localparam bit TmoEn = 1'b1;
`else
   localparam bit TmoEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] entry_req, exit_req;
   logic       car_pass, parking_full;
   logic [3:0] free_spots;
   logic [3:0] gnt;
   logic       barrier_open, car_in, car_out, busy, timeout_err;

   park_gate_arbiter #(
      .CAPACITY    (CAPACITY),
      .CLOSE_CYCLES(CLOSE_CYCLES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .entry_req   (entry_req),
      .exit_req    (exit_req),
      .car_pass    (car_pass),
      .free_spots  (free_spots),
      .parking_full(parking_full),
      .gnt         (gnt),
      .barrier_open(barrier_open),
      .car_in      (car_in),
      .car_out     (car_out),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       tmo;
      logic       cout;
      logic       cin;
      logic       busy;
      logic       bar;
      logic [3:0] gnt;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_en = 1'b0;
   int   n_vec  = 0;
   int   n_bad  = 0;

   // Model state: last granted gate, phase (0 idle, 1 barrier open, 2 busy tail)
   int         m_ptr, m_phase, m_ocnt, m_drain;
   logic [3:0] m_gnt;

   function automatic exp_t outs();
      return exp_t'({timeout_err, car_out, car_in, busy, barrier_open, gnt});
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s t=%0t actual={tmo,out,in,busy,bar,gnt}=%b required=%b",
                  name, $time, act, req);
      end
   endtask

   // Predicts the outputs of the next cycle from this cycle's inputs.
   task automatic model_step();
      exp_t       e;
      logic [3:0] elig;
      int         sel;
      e = '0;
      if (m_phase == 0) begin
         elig[1:0] = parking_full ? 2'b00 : entry_req;
         elig[3:2] = (free_spots == CAPACITY) ? 2'b00 : exit_req;
         sel = -1;
         for (int k = 1; k <= 4; k++) begin
            if (sel < 0 && elig[(m_ptr + k) % 4]) sel = (m_ptr + k) % 4;
         end
         if (sel >= 0) begin
            m_ptr   = sel;
            m_gnt   = 4'b0001 << sel;
            m_phase = 1;
            m_ocnt  = 0;
            e.busy  = 1'b1;
            e.bar   = 1'b1;
            e.gnt   = m_gnt;
         end
      end else if (m_phase == 1) begin
         if (car_pass) begin
            m_phase = 2;
            m_drain = 1 + CLOSE_CYCLES;
            e.busy  = 1'b1;
            e.bar   = 1'b1;
            e.gnt   = m_gnt;
            e.cin   = (m_gnt[1:0] != 2'b00);
            e.cout  = (m_gnt[3:2] != 2'b00);
         end else if (TmoEn && m_ocnt == TIMEOUT - 1) begin
            m_phase = 2;
            m_drain = CLOSE_CYCLES;
            e.busy  = 1'b1;
            e.tmo   = 1'b1;
         end else begin
            m_ocnt++;
            e.busy = 1'b1;
            e.bar  = 1'b1;
            e.gnt  = m_gnt;
         end
      end else begin
         m_drain--;
         if (m_drain == 0) m_phase = 0;
         else e.busy = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compares one expected vector per cycle at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", outs(), e);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      entry_req = '0;
      exit_req = '0;
      car_pass = 1'b0;
      parking_full = 1'b0;
      free_spots = 4'd5;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", outs(), '0);

      m_ptr   = 3;
      m_phase = 0;
      rst     = 1'b0;
      exp_q.push_back('0);
      model_step();
      mon_en = 1'b1;

      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(3) == 0) entry_req = 2'($urandom);
         if ($urandom_range(3) == 0) exit_req = 2'($urandom);
         free_spots   = ($urandom_range(2) == 0) ? 4'(CAPACITY) : 4'($urandom);
         parking_full = ($urandom_range(3) == 0);
         // A long stretch with no car crossing exercises the open-wait behaviour.
         car_pass     = (c >= 600 && c < 720) ? 1'b0 : ($urandom_range(4) == 0);
         model_step();
      end
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      exp_q.delete();

      // Reset during OPEN drops everything at once and no car is reported afterwards.
      @(posedge clk);
      #1;
      rst = 1'b1;
      entry_req = 2'b01;
      exit_req = 2'b00;
      parking_full = 1'b0;
      free_spots = 4'd5;
      car_pass = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("grant_after_reset", outs(), exp_t'(9'b0_0_0_1_1_0001));
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_in_open", outs(), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      entry_req = 2'b00;
      car_pass = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("no_pulse_after_reset", outs(), '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/park_gate_arbiter.md
PARK_GATE_ARBITER -- requirements
Module: park_gate_arbiter

Interface
REQ-001 CAPACITY, 12, total spots of the managed park_system; SHALL be <=15.
REQ-002 CLOSE_CYCLES, 4, barrier closing time in clk cycles.
REQ-003 TIMEOUT, 16, OPEN-state wait limit in cycles; used only with PARK_TIMEOUT_EN.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 entry_req  input  2  per-entry-gate level request.
REQ-007 exit_req  input  2  per-exit-gate level request.
REQ-008 car_pass  input  1  one-cycle sensor pulse: granted car crossed the barrier.
REQ-009 free_spots  input  4  free spot count from park_system.
REQ-010 parking_full  input  1  full flag from park_system.
REQ-011 gnt  output  4  one-hot grant; [1:0] entry gates 0/1, [3:2] exit gates 0/1.
REQ-012 barrier_open  output  1  barrier drive.
REQ-013 car_in  output  1  one-cycle pulse to park_system car_in.
REQ-014 car_out  output  1  one-cycle pulse to park_system car_out.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 timeout_err  output  1  one-cycle abort pulse.

Function
REQ-017 FSM states SHALL be IDLE, OPEN, COMMIT, CLOSE; one transaction at a time; grants issued only from IDLE.
REQ-018 Eligible vector SHALL be {exit_req masked when free_spots==CAPACITY, entry_req masked when parking_full==1}, index order 0..3 = gnt bit order.
REQ-019 In IDLE with a nonzero eligible vector, the block SHALL pick round-robin starting at the index after the last granted one, register gnt, update the pointer, and enter OPEN.
REQ-020 Latency: eligible request in cycle N -> gnt and barrier_open high in cycle N+1.
REQ-021 OPEN: gnt and barrier_open held high; car_pass -> COMMIT next cycle; request deassertion ignored.
REQ-022 COMMIT lasts exactly one cycle: car_in=1 for an entry grant, car_out=1 for an exit grant; gnt and barrier_open still high; next CLOSE.
REQ-023 CLOSE: gnt=0, barrier_open=0, busy=1 for exactly CLOSE_CYCLES cycles, then IDLE.
REQ-024 car_in and car_out SHALL never be high in the same cycle; car_pass outside OPEN ignored.
REQ-025 parking_full or free_spots changing after grant SHALL NOT abort the transaction.

Reset
REQ-026 rst high SHALL immediately force state IDLE, all outputs 0, round-robin pointer 3 (gate index 0 first), counters 0.
REQ-027 Reset mid-transaction SHALL abort it with no car_in/car_out pulse.

Configuration
REQ-028 PARK_TIMEOUT_EN defined: counter runs in OPEN; after TIMEOUT cycles without car_pass, timeout_err pulses one cycle, FSM enters CLOSE, no car_in/car_out.
REQ-029 PARK_TIMEOUT_EN undefined: OPEN waits indefinitely, no timeout counter, timeout_err tied 0.

Verification
REQ-030 entry_req=01 from cycle 2, car_pass in cycle 6 -> gnt=0001, barrier_open=1 cycles 3-7; car_in=1 cycle 7 only; busy low from cycle 12.
REQ-031 entry_req=11, exit_req=11 held, free_spots=5, car_pass each OPEN -> grant order index 0,1,2,3,0.
REQ-032 parking_full=1, entry_req=11 -> gnt=0000, busy=0; add exit_req=01, free_spots=0 -> gnt=0100, car_out pulse after car_pass.
REQ-033 free_spots=12, parking_full=0, exit_req=11, entry_req=00 -> no grant, busy=0.
REQ-034 PARK_TIMEOUT_EN, TIMEOUT=16, entry grant, no car_pass -> timeout_err pulse 16 cycles after OPEN entry, car_in never high; macro undefined -> still OPEN after 100 cycles.
REQ-035 rst asserted during OPEN -> gnt, barrier_open, busy 0 in the same cycle; no car_in after release.
